// File: rtl/sadd_arb_pkg.sv
// Shared defaults, state encoding and elaboration helpers for the round-robin signed-add arbiter.
package sadd_arb_pkg;

    localparam int unsigned DATAWIDTH_DEF = 8;
    localparam int unsigned NREQ_DEF      = 4;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    // Smallest r with 2**r >= v; loop is bounded so it folds at elaboration.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sadd_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request strictly after 'last', wrapping modulo NREQ.
module rr_pick
    import sadd_arb_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned IDW  = clog2(NREQ_DEF)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last,
    input  logic            en,
    output logic [NREQ-1:0] grant_c
);

    logic [IDW-1:0]    start_c;
    logic [2*NREQ-1:0] dbl_c;
    logic [2*NREQ-1:0] back_c;
    logic [NREQ-1:0]   rot_c;
    logic [NREQ-1:0]   first_c;

    // Rotate so the search origin lands at bit 0, isolate the lowest set bit, rotate back.
    always_comb begin
        start_c = (last >= IDW'(NREQ - 1)) ? '0 : IDW'(last + 1'b1);
        dbl_c   = {req, req} >> start_c;
        rot_c   = dbl_c[NREQ-1:0];
        first_c = rot_c & (~rot_c + 1'b1);
        back_c  = {first_c, first_c} << start_c;
        grant_c = en ? back_c[2*NREQ-1:NREQ] : '0;
    end

endmodule

// File: rtl/sadd_rr_arbiter_sadd.sv
// Signed wrap-around adder datapath component.
module sadd #(
    parameter int unsigned W = 8
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] sum_c
);

    assign sum_c = a + b;

endmodule

// File: rtl/sadd_rr_arbiter.sv
// Round-robin arbiter time-multiplexing one signed adder over NREQ requesters, one-entry result register.
// Optional overflow flag output res_ovf enabled by defining SADD_RR_ARBITER_OVF_EN.
module sadd_rr_arbiter
    import sadd_arb_pkg::*;
#(
    parameter int unsigned DATAWIDTH = DATAWIDTH_DEF,
    parameter int unsigned NREQ      = NREQ_DEF,
    parameter int unsigned IDW       = clog2(NREQ_DEF)
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*DATAWIDTH-1:0] req_a,
    input  logic [NREQ*DATAWIDTH-1:0] req_b,
    output logic [NREQ-1:0]           req_ready,
    output logic                      res_valid,
    output logic [DATAWIDTH-1:0]      res_sum,
    output logic [IDW-1:0]            res_id,
    input  logic                      res_ready
`ifdef SADD_RR_ARBITER_OVF_EN
    ,
    output logic                      res_ovf
`endif
);

    if (clog2(NREQ) > IDW) begin : g_idw_check
        $error("sadd_rr_arbiter: IDW too narrow for NREQ");
    end

    state_e               state_q, state_d;
    logic [IDW-1:0]       last_q, last_d;
    logic [IDW-1:0]       id_q, id_d;
    logic [DATAWIDTH-1:0] sum_q, sum_d;
`ifdef SADD_RR_ARBITER_OVF_EN
    logic                 ovf_q, ovf_d;
`endif

    logic                 can_accept_c;
    logic                 xfer_c;
    logic [NREQ-1:0]      grant_c;
    logic [IDW-1:0]       gnt_id_c;
    logic [DATAWIDTH-1:0] a_sel_c;
    logic [DATAWIDTH-1:0] b_sel_c;
    logic [DATAWIDTH-1:0] add_sum_c;

    assign can_accept_c = (state_q == EMPTY) || res_ready;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req     (req_valid),
        .last    (last_q),
        .en      (can_accept_c && !Rst),
        .grant_c (grant_c)
    );

    assign req_ready = grant_c;
    assign xfer_c    = |grant_c;

    // Grant is one-hot, so OR-ing masked lanes selects the winner's operands.
    always_comb begin
        a_sel_c  = '0;
        b_sel_c  = '0;
        gnt_id_c = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (grant_c[i]) begin
                a_sel_c  = a_sel_c | req_a[i*DATAWIDTH +: DATAWIDTH];
                b_sel_c  = b_sel_c | req_b[i*DATAWIDTH +: DATAWIDTH];
                gnt_id_c = IDW'(i);
            end
        end
    end

    sadd #(
        .W (DATAWIDTH)
    ) u_add (
        .a     (a_sel_c),
        .b     (b_sel_c),
        .sum_c (add_sum_c)
    );

    // Next-state: a transfer loads (and may replace) the result; a lone drain only clears valid.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        id_d    = id_q;
        sum_d   = sum_q;
`ifdef SADD_RR_ARBITER_OVF_EN
        ovf_d   = ovf_q;
`endif
        if (xfer_c) begin
            state_d = FULL;
            last_d  = gnt_id_c;
            id_d    = gnt_id_c;
            sum_d   = add_sum_c;
`ifdef SADD_RR_ARBITER_OVF_EN
            ovf_d   = (a_sel_c[DATAWIDTH-1] == b_sel_c[DATAWIDTH-1]) &&
                      (add_sum_c[DATAWIDTH-1] != a_sel_c[DATAWIDTH-1]);
`endif
        end else if ((state_q == FULL) && res_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= EMPTY;
            last_q  <= IDW'(NREQ - 1);
            id_q    <= '0;
            sum_q   <= '0;
`ifdef SADD_RR_ARBITER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            sum_q   <= sum_d;
`ifdef SADD_RR_ARBITER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign res_valid = (state_q == FULL);
    assign res_sum   = sum_q;
    assign res_id    = id_q;
`ifdef SADD_RR_ARBITER_OVF_EN
    assign res_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_sadd_rr_arbiter.sv
// Scoreboard bench for sadd_rr_arbiter: directed scenarios followed by randomized traffic.
module tb_sadd_rr_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = 2;

    logic           Clk = 1'b0;
    logic           Rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_ready;
    logic           res_valid;
    logic [W-1:0]   res_sum;
    logic [IW-1:0]  res_id;
    logic           res_ready;
`ifdef SADD_RR_ARBITER_OVF_EN
    logic           res_ovf;
`endif

    logic [W-1:0] a_op [N];
    logic [W-1:0] b_op [N];

    sadd_rr_arbiter #(
        .DATAWIDTH (W),
        .NREQ      (N),
        .IDW       (IW)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_sum   (res_sum),
        .res_id    (res_id),
        .res_ready (res_ready)
`ifdef SADD_RR_ARBITER_OVF_EN
        ,
        .res_ovf   (res_ovf)
`endif
    );

    always #5 Clk = ~Clk;

    always_comb begin
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = a_op[i];
            req_b[i*W +: W] = b_op[i];
        end
    end

    typedef struct {
        logic [W-1:0]  sum;
        logic [IW-1:0] id;
        logic          ovf;
    } res_t;

    res_t         exp_q[$];
    res_t         hold = '{sum: '0, id: '0, ovf: 1'b0};
    int           m_last = N - 1;
    logic [N-1:0] exp_ready = '0;
    int           checks = 0;
    int           errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare presented result against the scoreboard head (or the held value when empty).
    task automatic monitor_step();
        res_t cur;
        check("res_valid", 32'(res_valid), 32'(exp_q.size() != 0));
        cur = (exp_q.size() != 0) ? exp_q[0] : hold;
        check("res_sum", 32'(res_sum), 32'(cur.sum));
        check("res_id", 32'(res_id), 32'(cur.id));
`ifdef SADD_RR_ARBITER_OVF_EN
        check("res_ovf", 32'(res_ovf), 32'(cur.ovf));
`endif
        if (exp_q.size() != 0 && res_ready) begin
            void'(exp_q.pop_front());
        end
    endtask

    // Reference: one result slot, priority search starting after the last winner.
    task automatic model_step();
        int   g;
        int   idx;
        int   s;
        res_t r;
        g = -1;
        if (!Rst && exp_q.size() == 0) begin
            for (int k = 1; k <= N; k++) begin
                idx = (m_last + k) % N;
                if (g < 0 && req_valid[idx]) g = idx;
            end
        end
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        if (Rst) begin
            exp_q.delete();
            m_last = N - 1;
            hold   = '{sum: '0, id: '0, ovf: 1'b0};
        end else if (g >= 0) begin
            s     = int'($signed(a_op[g])) + int'($signed(b_op[g]));
            r.sum = s[W-1:0];
            r.id  = IW'(g);
            r.ovf = (s > 127) || (s < -128);
            exp_q.push_back(r);
            hold   = r;
            m_last = g;
        end
    endtask

    always @(negedge Clk) begin
        monitor_step();
        model_step();
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        a_op[i] = a;
        b_op[i] = b;
    endtask

    initial begin
        Rst       = 1'b1;
        req_valid = '0;
        res_ready = 1'b0;
        for (int i = 0; i < N; i++) set_op(i, '0, '0);

        // Reset and idle
        step();
        step();
        Rst = 1'b0;
        step();

        // Single request: 5 + (-3)
        set_op(0, 8'd5, 8'hFD);
        req_valid = 4'b0001;
        res_ready = 1'b1;
        step();
        req_valid = '0;
        step();

        // Round-robin with all requesters active
        for (int i = 0; i < N; i++) set_op(i, W'($urandom), W'($urandom));
        req_valid = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            step();
            for (int i = 0; i < N; i++) set_op(i, W'($urandom), W'($urandom));
        end
        req_valid = '0;
        step();

        // Back-pressure
        res_ready = 1'b0;
        set_op(0, 8'd10, 8'd20);
        req_valid = 4'b0001;
        step();
        set_op(1, 8'd7, 8'hF0);
        req_valid = 4'b0010;
        for (int c = 0; c < 3; c++) step();
        res_ready = 1'b1;
        step();
        req_valid = '0;
        step();
        step();

        // Wrap and overflow at both extremes
        set_op(2, 8'd127, 8'd1);
        req_valid = 4'b0100;
        step();
        set_op(2, 8'h80, 8'hFF);
        step();
        req_valid = '0;
        step();

        // Reset while holding a result
        res_ready = 1'b0;
        set_op(0, 8'd3, 8'd4);
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        step();
        Rst = 1'b1;
        step();
        Rst = 1'b0;
        res_ready = 1'b1;
        set_op(3, 8'd50, 8'd60);
        req_valid = 4'b1000;
        step();
        set_op(0, 8'd1, 8'd1);
        req_valid = 4'b1001;
        step();
        req_valid = '0;
        step();

        // Randomized traffic; waiting requesters keep valid and operands stable
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!(req_valid[i] && !exp_ready[i])) begin
                    req_valid[i] = ($urandom_range(0, 1) == 1);
                    set_op(i, W'($urandom), W'($urandom));
                end
            end
            res_ready = ($urandom_range(0, 3) != 0);
            Rst       = ($urandom_range(0, 149) == 0);
            step();
        end
        Rst       = 1'b0;
        req_valid = '0;
        res_ready = 1'b1;
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
